// File: rtl/riscv_mdu_divider.sv
// riscv_mdu_divider: multi-cycle radix-2 restoring DIV/DIVU/REM/REMU unit with tag pass-through.
// Define DIV_EARLY_OUT_EN to let divide-by-zero and signed overflow skip the iteration phase.
module riscv_mdu_divider #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic [TAG_W-1:0] tag_in,
  output logic             busy,
  output logic             valid,
  output logic [WIDTH-1:0] result,
  output logic [TAG_W-1:0] tag_out
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
  state_t           state;
  logic [WIDTH-1:0] a_mag, b_mag, quo, rem;
  logic [CW-1:0]    cnt;
  logic             is_rem, qneg, rneg, div0;
  logic [TAG_W-1:0] tag_q;
  logic             sgn, a_neg, b_neg, skip;
  logic [WIDTH-1:0] a_abs, b_abs, q_fix, r_fix;
  logic [WIDTH:0]   trial;
  assign sgn   = ~op[0];
  assign a_neg = sgn & dividend[WIDTH-1];
  assign b_neg = sgn & divisor[WIDTH-1];
  assign a_abs = a_neg ? -dividend : dividend;
  assign b_abs = b_neg ? -divisor : divisor;
  assign trial = {rem, quo[WIDTH-1]} - {1'b0, b_mag};
  // Re-applying the dividend sign to its magnitude restores the original operand for the div-by-zero remainder.
  assign q_fix = div0 ? '1 : (qneg ? -quo : quo);
  assign r_fix = div0 ? (rneg ? -a_mag : a_mag) : (rneg ? -rem : rem);
`ifdef DIV_EARLY_OUT_EN
  // Overflow needs no override: magnitude 100..0 divided by 1 with positive sign already yields 100..0 rem 0.
  assign skip = (divisor == '0) | (sgn & (dividend == {1'b1, {(WIDTH-1){1'b0}}}) & (&divisor));
`else
  assign skip = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      busy    <= 1'b0;
      valid   <= 1'b0;
      result  <= '0;
      tag_out <= '0;
    end else begin
      valid <= 1'b0;
      if (flush) begin
        state <= IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          IDLE: if (start) begin
            a_mag  <= a_abs;
            b_mag  <= b_abs;
            quo    <= a_abs;
            rem    <= '0;
            cnt    <= CW'(WIDTH-1);
            is_rem <= op[1];
            qneg   <= a_neg ^ b_neg;
            rneg   <= a_neg;
            div0   <= divisor == '0;
            tag_q  <= tag_in;
            busy   <= 1'b1;
            state  <= skip ? FIX : CALC;
          end
          CALC: begin
            rem <= trial[WIDTH] ? {rem[WIDTH-2:0], quo[WIDTH-1]} : trial[WIDTH-1:0];
            quo <= {quo[WIDTH-2:0], ~trial[WIDTH]};
            cnt <= cnt - 1'b1;
            if (cnt == '0) state <= FIX;
          end
          FIX: begin
            result  <= is_rem ? r_fix : q_fix;
            tag_out <= tag_q;
            valid   <= 1'b1;
            busy    <= 1'b0;
            state   <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_riscv_mdu_divider.sv
// tb_riscv_mdu_divider: directed-vector bench for riscv_mdu_divider at WIDTH=32.
module tb_riscv_mdu_divider;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic [4:0]  tag_in = '0;
  logic        busy, valid;
  logic [31:0] result;
  logic [4:0]  tag_out;
  int n_cmp = 0;
  int n_err = 0;
  int cyc;
  int vcnt;
`ifdef DIV_EARLY_OUT_EN
  localparam int SP_LAT = 2;
`else
  localparam int SP_LAT = 34;
`endif

  riscv_mdu_divider #(.WIDTH(32), .TAG_W(5)) dut (
    .clk(clk), .rst(rst), .flush(flush), .start(start), .op(op),
    .dividend(dividend), .divisor(divisor), .tag_in(tag_in),
    .busy(busy), .valid(valid), .result(result), .tag_out(tag_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic s, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input logic [4:0] t);
    start = s; op = o; dividend = a; divisor = b; tag_in = t;
  endtask

  task automatic do_op(input string name, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] t, input logic [31:0] exp, input int lat);
    @(negedge clk);
    drive(1'b1, o, a, b, t);
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    check({name, "_busy1"}, 64'(busy), 64'd1);
    while (!valid && cyc < 80) begin
      @(negedge clk);
      cyc++;
    end
    check({name, "_lat"}, 64'(cyc), 64'(lat));
    check({name, "_res"}, 64'(result), 64'(exp));
    check({name, "_tag"}, 64'(tag_out), 64'(t));
    check({name, "_busy_at_valid"}, 64'(busy), 64'd0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_valid", 64'(valid), 64'd0);
    check("rst_result", 64'(result), 64'd0);
    check("rst_tag", 64'(tag_out), 64'd0);
    rst = 1'b0;

    do_op("div_m7_2",    2'b00, 32'hFFFF_FFF9, 32'd2, 5'd1, 32'hFFFF_FFFD, 34);
    do_op("rem_m7_2",    2'b10, 32'hFFFF_FFF9, 32'd2, 5'd2, 32'hFFFF_FFFF, 34);
    do_op("divu_100_7",  2'b01, 32'd100, 32'd7, 5'd3, 32'd14, 34);
    do_op("remu_100_7",  2'b11, 32'd100, 32'd7, 5'd4, 32'd2, 34);
    do_op("div_7_m2",    2'b00, 32'd7, 32'hFFFF_FFFE, 5'd5, 32'hFFFF_FFFD, 34);
    do_op("rem_7_m2",    2'b10, 32'd7, 32'hFFFF_FFFE, 5'd6, 32'd1, 34);
    do_op("div_5_0",     2'b00, 32'd5, 32'd0, 5'd7, 32'hFFFF_FFFF, SP_LAT);
    do_op("rem_5_0",     2'b10, 32'd5, 32'd0, 5'd8, 32'd5, SP_LAT);
    do_op("rem_m5_0",    2'b10, 32'hFFFF_FFFB, 32'd0, 5'd9, 32'hFFFF_FFFB, SP_LAT);
    do_op("divu_big_0",  2'b01, 32'h8000_0000, 32'd0, 5'd10, 32'hFFFF_FFFF, SP_LAT);
    do_op("remu_big_0",  2'b11, 32'h8000_0000, 32'd0, 5'd11, 32'h8000_0000, SP_LAT);
    do_op("div_ovf",     2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'h8000_0000, SP_LAT);
    do_op("rem_ovf",     2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 32'd0, SP_LAT);
    do_op("divu_ovfpat", 2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 32'd0, 34);
    do_op("remu_ovfpat", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 32'h8000_0000, 34);

    // start while busy is ignored; start in the valid cycle is accepted
    @(negedge clk);
    drive(1'b1, 2'b01, 32'd100, 32'd7, 5'd3);
    vcnt = 0;
    for (int c = 1; c <= 68; c++) begin
      @(negedge clk);
      if (valid) vcnt++;
      if (c == 1 || c == 11 || c == 35) start = 1'b0;
      if (c == 10) drive(1'b1, 2'b00, 32'd50, 32'd5, 5'd9);
      if (c == 34) begin
        check("bp_valid34", 64'(valid), 64'd1);
        check("bp_res34", 64'(result), 64'd14);
        check("bp_tag34", 64'(tag_out), 64'd3);
        check("bp_vcnt34", 64'(vcnt), 64'd1);
        drive(1'b1, 2'b11, 32'd100, 32'd7, 5'd4);
      end
      if (c == 68) begin
        check("b2b_valid68", 64'(valid), 64'd1);
        check("b2b_res68", 64'(result), 64'd2);
        check("b2b_tag68", 64'(tag_out), 64'd4);
        check("b2b_vcnt", 64'(vcnt), 64'd2);
      end
    end

    // flush in cycle 15, restart in cycle 16
    @(negedge clk);
    drive(1'b1, 2'b01, 32'd1000, 32'd10, 5'd5);
    vcnt = 0;
    for (int c = 1; c <= 50; c++) begin
      @(negedge clk);
      if (valid && c < 50) vcnt++;
      if (c == 1) start = 1'b0;
      if (c == 15) flush = 1'b1;
      if (c == 16) begin
        flush = 1'b0;
        check("fl_busy16", 64'(busy), 64'd0);
        drive(1'b1, 2'b01, 32'd1000, 32'd10, 5'd7);
      end
      if (c == 17) start = 1'b0;
      if (c == 20) check("fl_res_hold", 64'(result), 64'd2);
      if (c == 50) begin
        check("fl_novalid", 64'(vcnt), 64'd0);
        check("fl_valid50", 64'(valid), 64'd1);
        check("fl_res50", 64'(result), 64'd100);
        check("fl_tag50", 64'(tag_out), 64'd7);
      end
    end

    // reset in cycle 20 of an operation
    @(negedge clk);
    drive(1'b1, 2'b01, 32'd1000, 32'd10, 5'd5);
    vcnt = 0;
    for (int c = 1; c <= 45; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
      if (c == 20) rst = 1'b1;
      if (c == 21) begin
        rst = 1'b0;
        check("rs_busy", 64'(busy), 64'd0);
        check("rs_valid", 64'(valid), 64'd0);
        check("rs_result", 64'(result), 64'd0);
        check("rs_tag", 64'(tag_out), 64'd0);
      end
      if (c > 21 && valid) vcnt++;
    end
    check("rs_novalid", 64'(vcnt), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
